// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues
// word fetches to instruction memory over a req/ack handshake, keeps one early
// return in a side buffer while decode is stalled, and drives the IF/ID
// pipeline register consumed by the decode stage.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   imem_req       fetch request; address held while req=1 and ack=0
//   imem_addr      fetch address, always word aligned
//   imem_ack       read data valid; completes the outstanding request
//   imem_rdata     fetched instruction
//   stall          hold PC and IF/ID
//   flush          replace IF/ID with a bubble at the next edge
//   branch_taken   redirect the PC this cycle
//   branch_target  redirect address (low two bits ignored)
//   instruction    IF/ID instruction
//   pcPlus4        IF/ID PC+4 of that instruction
//   if_id_valid    IF/ID holds a real instruction
//
// State      | meaning
// -----------+------------------------------------------------------------
// S_FETCH    | request outstanding at r_fetch_addr, return is used
// S_DISCARD  | request outstanding at old address, return is dropped
//            | (a redirect arrived before its ack); r_pc holds the target
// S_BUFFERED | no request; one returned instruction parked in the buffer
//            | until stall clears

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DISCARD  = 2'd1,
    S_BUFFERED = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_addr;
  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pcp4;
  logic [31:0] r_instr;
  logic [31:0] r_pcp4;
  logic        r_valid;

  state_t      w_nxt_state;
  logic [31:0] w_nxt_pc;
  logic [31:0] w_nxt_fetch_addr;
  logic        w_nxt_buf_valid;
  logic [31:0] w_nxt_buf_instr;
  logic [31:0] w_nxt_buf_pcp4;
  logic [31:0] w_nxt_instr;
  logic [31:0] w_nxt_pcp4;
  logic        w_nxt_valid;

  logic [31:0] w_fa_p4;
  logic [31:0] w_tgt;

  assign w_fa_p4 = r_fetch_addr + 32'd4;
  assign w_tgt   = branch_target & ~32'h3;

  // req is gated by rst so it stays low during the reset cycle itself and
  // rises on the first cycle after rst drops.
  assign imem_req    = !rst && (r_state != S_BUFFERED);
  assign imem_addr   = r_fetch_addr;
  assign instruction = r_instr;
  assign pcPlus4     = r_pcp4;
  assign if_id_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC_AL;
      r_fetch_addr <= RESET_PC_AL;
      r_buf_valid  <= 1'b0;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pcp4   <= 32'h0;
      r_instr      <= NOP_INSTR;
      r_pcp4       <= 32'h0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      r_fetch_addr <= w_nxt_fetch_addr;
      r_buf_valid  <= w_nxt_buf_valid;
      r_buf_instr  <= w_nxt_buf_instr;
      r_buf_pcp4   <= w_nxt_buf_pcp4;
      r_instr      <= w_nxt_instr;
      r_pcp4       <= w_nxt_pcp4;
      r_valid      <= w_nxt_valid;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_fetch_addr = r_fetch_addr;
    w_nxt_buf_valid  = r_buf_valid;
    w_nxt_buf_instr  = r_buf_instr;
    w_nxt_buf_pcp4   = r_buf_pcp4;
    w_nxt_instr      = r_instr;
    w_nxt_pcp4       = r_pcp4;
    w_nxt_valid      = r_valid;

    if (branch_taken) begin
      // Redirect beats stall and ack; anything fetched on the old path is lost.
      w_nxt_pc        = w_tgt;
      w_nxt_buf_valid = 1'b0;
      w_nxt_instr     = NOP_INSTR;
      w_nxt_pcp4      = 32'h0;
      w_nxt_valid     = 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            w_nxt_fetch_addr = w_tgt;
          end else begin
            // Memory still owes us a word for the old address; keep the
            // address stable and throw that word away when it arrives.
            w_nxt_state = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            w_nxt_fetch_addr = w_tgt;
            w_nxt_state      = S_FETCH;
          end
        end
        default: begin
          w_nxt_fetch_addr = w_tgt;
          w_nxt_state      = S_FETCH;
        end
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            w_nxt_pc = w_fa_p4;
            if (flush) begin
              // The returning word is squashed; fetching carries on past it.
              w_nxt_fetch_addr = w_fa_p4;
            end else if (stall) begin
              w_nxt_buf_instr = imem_rdata;
              w_nxt_buf_pcp4  = w_fa_p4;
              w_nxt_buf_valid = 1'b1;
              w_nxt_state     = S_BUFFERED;
            end else begin
              w_nxt_instr      = imem_rdata;
              w_nxt_pcp4       = w_fa_p4;
              w_nxt_valid      = 1'b1;
              w_nxt_fetch_addr = w_fa_p4;
            end
          end
          if (flush || (!stall && !imem_ack)) begin
            w_nxt_instr = NOP_INSTR;
            w_nxt_pcp4  = 32'h0;
            w_nxt_valid = 1'b0;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            w_nxt_fetch_addr = r_pc;
            w_nxt_state      = S_FETCH;
          end
          if (flush || !stall) begin
            w_nxt_instr = NOP_INSTR;
            w_nxt_pcp4  = 32'h0;
            w_nxt_valid = 1'b0;
          end
        end
        S_BUFFERED: begin
          if (flush || !stall) begin
            // r_pc already points past the buffered word.
            w_nxt_fetch_addr = r_pc;
            w_nxt_buf_valid  = 1'b0;
            w_nxt_state      = S_FETCH;
            if (flush) begin
              w_nxt_instr = NOP_INSTR;
              w_nxt_pcp4  = 32'h0;
              w_nxt_valid = 1'b0;
            end else begin
              w_nxt_instr = r_buf_instr;
              w_nxt_pcp4  = r_buf_pcp4;
              w_nxt_valid = 1'b1;
            end
          end
        end
        default: begin
          w_nxt_fetch_addr = r_pc;
          w_nxt_buf_valid  = 1'b0;
          w_nxt_state      = S_FETCH;
        end
      endcase
    end
  end

endmodule
